cpu_bus_bridge: RTL and testbench

Parametrised successor to the FPGA's 68000 bus decoder. It synchronises the asynchronous CPU strobes into `sysclk` and decodes a configurable window into `NSLOT` peripheral slots. It runs a request/acknowledge handshake per access, so slots can insert wait states, and it generates DTACK, BERR and interrupt-acknowledge responses from a state machine. It sits between the CPU pins and the timers, interrupt controller, RTC and SPI blocks, replacing their ad-hoc per-address decode.

---
 rtl/cpu_bus_bridge_pkg.sv | 24 ++
 rtl/cpu_bus_bridge_sync.sv | 26 ++
 rtl/cpu_bus_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_bridge_pkg.sv
// cpu_bridge_pkg: shared types and constants for the 68000 bus bridge.
// Holds the bridge FSM state encoding, CPU bus widths, the IACK function
// code and the slot-index width helper.
package cpu_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4,
    ST_IACK = 3'd5
  } state_t;

  localparam logic [2:0] FC_IACK = 3'b111;
  localparam int         CPU_AW  = 19;
  localparam int         CPU_DW  = 16;

  // A single slot still needs one index bit so that the select slice is legal.
  function automatic int sel_w(input int nslot);
    return (nslot > 1) ? $clog2(nslot) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_bridge_sync.sv
// bus_sync: parametrised-width two-flop synchroniser. Each bit resets to
// its own value so that active-low CPU strobes come out of reset inactive.
module bus_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous inputs into sysclk.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: synchronises the 68000 strobes into sysclk, decodes the
// FPGA window into NSLOT peripheral slots with a req/ack handshake and
// produces DTACK, BERR and interrupt-acknowledge responses.
// Optional feature macro: CPU_BRIDGE_BERR_EN builds the bus-error timeout
// counter and ERR path; without it WAIT is unbounded, berr_n is tied high
// and unmapped accesses complete with DTACK and 16'hFFFF.
//
// state | meaning
// IDLE  | no access; watch synchronised AS / strobes / FC
// REQ   | one-cycle slot request, access fields latched
// WAIT  | slot inserting wait states (timeout running if enabled)
// ACK   | DTACK asserted, read data driven, wait for AS release
// ERR   | BERR asserted, wait for AS release
// IACK  | interrupt acknowledge: vector + DTACK or VPA autovector
module cpu_bus_bridge
  import cpu_bridge_pkg::*;
#(
  parameter int NSLOT    = 8,
  parameter int SLOT_LSB = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  as_n,
  input  logic                  rdh_n,
  input  logic                  rdl_n,
  input  logic                  wrh_n,
  input  logic                  wrl_n,
  input  logic                  fpga_cs_n,
  input  logic [2:0]            cpu_fc,
  input  logic [CPU_AW-1:0]     cpu_addr,
  input  logic [CPU_DW-1:0]     cpu_din,
  output logic [CPU_DW-1:0]     cpu_dout,
  output logic                  cpu_doe_h,
  output logic                  cpu_doe_l,
  output logic                  dtack_n,
  output logic                  berr_n,
  output logic                  vpa_n,
  output logic                  slot_req,
  output logic [NSLOT-1:0]      slot_sel,
  output logic [SLOT_LSB-1:0]   slot_addr,
  output logic                  slot_we,
  output logic [1:0]            slot_be,
  output logic [CPU_DW-1:0]     slot_wdata,
  input  logic [NSLOT-1:0]      slot_ack,
  input  logic [16*NSLOT-1:0]   slot_rdata,
  input  logic [7:0]            iack_vector,
  input  logic                  iack_ack,
  input  logic                  iack_autovec,
  output logic                  iack_cycle_n
);

  localparam int               SEL_W   = sel_w(NSLOT);
  localparam logic [SEL_W:0]   NSLOT_V = (SEL_W+1)'(NSLOT);

  state_t state, state_next;

  logic [8:0] sync_in, sync_out;
  logic       as_s, rdh_s, rdl_s, wrh_s, wrl_s, cs_s;
  logic [2:0] fc_s;

  assign sync_in = {as_n, rdh_n, rdl_n, wrh_n, wrl_n, fpga_cs_n, cpu_fc};

  bus_sync #(
    .W       (9),
    .RST_VAL (9'b111111_000)
  ) u_sync (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .d      (sync_in),
    .q      (sync_out)
  );

  assign {as_s, rdh_s, rdl_s, wrh_s, wrl_s, cs_s, fc_s} = sync_out;

  logic             as_act, start_iack, start_acc, unmapped, wr_act, ack_sel;
  logic [1:0]       be_now;
  logic [SEL_W-1:0] idx;
  logic [NSLOT-1:0] sel_onehot;
  logic [15:0]      rdata_sel;
  logic             iack_got, iack_av;

  assign as_act     = ~as_s;
  assign start_iack = as_act && (fc_s == FC_IACK);
  assign start_acc  = as_act && !cs_s && !(rdh_s && rdl_s && wrh_s && wrl_s);
  assign idx        = cpu_addr[SLOT_LSB +: SEL_W];
  assign unmapped   = ((cpu_addr >> (SLOT_LSB + SEL_W)) != '0) || ({1'b0, idx} >= NSLOT_V);
  assign sel_onehot = NSLOT'(1) << idx;
  assign be_now     = {~wrh_s | ~rdh_s, ~wrl_s | ~rdl_s};
  assign wr_act     = ~wrh_s | ~wrl_s;
  assign ack_sel    = |(slot_ack & slot_sel);

  // Read-data mux driven by the latched one-hot select.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_sel[i]) rdata_sel = rdata_sel | slot_rdata[16*i +: 16];
    end
  end

`ifdef CPU_BRIDGE_BERR_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;

  // Timeout down-counter: loaded during REQ, terminal count at zero in WAIT.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state == ST_REQ) begin
      tmr <= TW'(TIMEOUT - 1);
    end else if (state == ST_WAIT && tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; an AS release in REQ/WAIT aborts silently.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_iack) begin
          state_next = ST_IACK;
        end else if (start_acc) begin
`ifdef CPU_BRIDGE_BERR_EN
          state_next = unmapped ? ST_ERR : ST_REQ;
`else
          state_next = unmapped ? ST_ACK : ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (!as_act)      state_next = ST_IDLE;
        else if (ack_sel) state_next = ST_ACK;
        else              state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!as_act)      state_next = ST_IDLE;
        else if (ack_sel) state_next = ST_ACK;
`ifdef CPU_BRIDGE_BERR_EN
        else if (tmr == '0) state_next = ST_ERR;
`endif
      end
      ST_ACK, ST_ERR, ST_IACK: begin
        if (!as_act) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Access-field latching, read-data capture and IACK response capture.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      slot_sel   <= '0;
      slot_addr  <= '0;
      slot_we    <= 1'b0;
      slot_be    <= 2'b00;
      slot_wdata <= '0;
      cpu_dout   <= 16'hFFFF;
      iack_got   <= 1'b0;
      iack_av    <= 1'b0;
    end else begin
      if (state == ST_IDLE && !start_iack && start_acc) begin
        slot_addr  <= cpu_addr[SLOT_LSB-1:0];
        slot_we    <= wr_act;
        slot_be    <= be_now;
        slot_wdata <= cpu_din;
        slot_sel   <= unmapped ? '0 : sel_onehot;
        cpu_dout   <= 16'hFFFF;
      end else if (state_next == ST_IDLE) begin
        slot_sel <= '0;
      end
      if ((state == ST_REQ || state == ST_WAIT) && state_next == ST_ACK && !slot_we) begin
        cpu_dout <= rdata_sel;
      end
      if (state == ST_IACK) begin
        if (iack_ack && !iack_got) begin
          iack_got <= 1'b1;
          iack_av  <= iack_autovec;
          if (!iack_autovec) cpu_dout[7:0] <= iack_vector;
        end
      end else begin
        iack_got <= 1'b0;
        iack_av  <= 1'b0;
      end
    end
  end

  // CPU responses and pad enables decoded from the current state.
  always_comb begin
    dtack_n      = 1'b1;
    berr_n       = 1'b1;
    vpa_n        = 1'b1;
    cpu_doe_h    = 1'b0;
    cpu_doe_l    = 1'b0;
    slot_req     = 1'b0;
    iack_cycle_n = 1'b1;
    case (state)
      ST_REQ: slot_req = 1'b1;
      ST_ACK: begin
        dtack_n   = 1'b0;
        cpu_doe_h = !slot_we && slot_be[1];
        cpu_doe_l = !slot_we && slot_be[0];
      end
`ifdef CPU_BRIDGE_BERR_EN
      ST_ERR: berr_n = 1'b0;
`endif
      ST_IACK: begin
        iack_cycle_n = 1'b0;
        if (iack_got) begin
          if (iack_av) begin
            vpa_n = 1'b0;
          end else begin
            dtack_n   = 1'b0;
            cpu_doe_l = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb_cpu_bus_bridge: randomized and directed accesses against a
// slot-arithmetic reference model of the bridge.
module tb_cpu_bus_bridge;

  localparam int NSLOT      = 8;
  localparam int SLOT_LSB   = 4;
  localparam int TIMEOUT    = 64;
  localparam int SLOT_WORDS = 1 << SLOT_LSB;

  logic                 sysclk = 1'b0;
  logic                 rst_n;
  logic                 as_n, rdh_n, rdl_n, wrh_n, wrl_n, fpga_cs_n;
  logic [2:0]           cpu_fc;
  logic [18:0]          cpu_addr;
  logic [15:0]          cpu_din, cpu_dout;
  logic                 cpu_doe_h, cpu_doe_l, dtack_n, berr_n, vpa_n;
  logic                 slot_req, slot_we;
  logic [NSLOT-1:0]     slot_sel, slot_ack;
  logic [SLOT_LSB-1:0]  slot_addr;
  logic [1:0]           slot_be;
  logic [15:0]          slot_wdata;
  logic [16*NSLOT-1:0]  slot_rdata;
  logic [7:0]           iack_vector;
  logic                 iack_ack, iack_autovec, iack_cycle_n;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_bus_bridge #(.NSLOT(NSLOT), .SLOT_LSB(SLOT_LSB), .TIMEOUT(TIMEOUT)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .as_n(as_n), .rdh_n(rdh_n), .rdl_n(rdl_n),
    .wrh_n(wrh_n), .wrl_n(wrl_n), .fpga_cs_n(fpga_cs_n), .cpu_fc(cpu_fc),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_doe_h(cpu_doe_h), .cpu_doe_l(cpu_doe_l), .dtack_n(dtack_n),
    .berr_n(berr_n), .vpa_n(vpa_n), .slot_req(slot_req), .slot_sel(slot_sel),
    .slot_addr(slot_addr), .slot_we(slot_we), .slot_be(slot_be),
    .slot_wdata(slot_wdata), .slot_ack(slot_ack), .slot_rdata(slot_rdata),
    .iack_vector(iack_vector), .iack_ack(iack_ack), .iack_autovec(iack_autovec),
    .iack_cycle_n(iack_cycle_n)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // At most one of the three CPU responses may be asserted.
  always @(negedge sysclk) begin
    int lows;
    lows = 0;
    if (dtack_n === 1'b0) lows++;
    if (berr_n === 1'b0)  lows++;
    if (vpa_n === 1'b0)   lows++;
    if (rst_n === 1'b1) chk("one_resp", 32'(lows <= 1), 32'd1);
  end

  task automatic idle_inputs();
    as_n = 1'b1; rdh_n = 1'b1; rdl_n = 1'b1; wrh_n = 1'b1; wrl_n = 1'b1;
    fpga_cs_n = 1'b1; cpu_fc = 3'b000; slot_ack = '0; iack_ack = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_dtack_n", dtack_n, 1);
    chk("rst_berr_n", berr_n, 1);
    chk("rst_vpa_n", vpa_n, 1);
    chk("rst_iack_cycle_n", iack_cycle_n, 1);
    chk("rst_doe", {cpu_doe_h, cpu_doe_l}, 0);
    chk("rst_slot_req", slot_req, 0);
    chk("rst_slot_we", slot_we, 0);
    chk("rst_slot_sel", slot_sel, 0);
    chk("rst_slot_be", slot_be, 0);
    chk("rst_slot_addr", slot_addr, 0);
    chk("rst_cpu_dout", cpu_dout, 32'hFFFF);
    chk("rst_slot_wdata", slot_wdata, 0);
  endtask

  task automatic release_bus();
    int n;
    idle_inputs();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sysclk);
      n++;
      if (dtack_n && berr_n && vpa_n && iack_cycle_n) break;
    end
    chk("release_lat", 32'(n <= 3), 1);
    chk("release_resp", {dtack_n, berr_n, vpa_n, iack_cycle_n}, 4'hF);
    chk("release_sel", slot_sel, 0);
  endtask

  // delay < 0 means the slot never acknowledges.
  task automatic run_access(input int waddr, input bit wr, input logic [1:0] lanes,
                            input logic [15:0] data, input int delay, input bit rst_mid);
    int  slot, req_edge, resp_edge, berr_edge, req_cnt;
    bit  mapped;
    logic [15:0] exp_rd;
    mapped = waddr < NSLOT * SLOT_WORDS;
    slot   = waddr / SLOT_WORDS;
    exp_rd = mapped ? slot_rdata[16*slot +: 16] : 16'hFFFF;
    req_edge = -1; resp_edge = -1; berr_edge = -1; req_cnt = 0;
    @(negedge sysclk);
    cpu_addr = 19'(waddr); cpu_din = data; cpu_fc = 3'b101; fpga_cs_n = 1'b0; as_n = 1'b0;
    if (wr) begin wrh_n = ~lanes[1]; wrl_n = ~lanes[0]; end
    else    begin rdh_n = ~lanes[1]; rdl_n = ~lanes[0]; end
    for (int c = 1; c <= 300; c++) begin
      @(negedge sysclk);
      if (slot_req) begin
        req_cnt++;
        if (req_edge < 0) begin
          req_edge = c;
          chk("req_sel", 32'(slot_sel), 32'd1 << slot);
          chk("req_addr", slot_addr, waddr % SLOT_WORDS);
          chk("req_we", slot_we, wr);
          chk("req_be", slot_be, lanes);
          if (wr) chk("req_wdata", slot_wdata, data);
        end
      end
      if (mapped && req_edge >= 0 && delay >= 0 && c == req_edge + delay) slot_ack[slot] = 1'b1;
      if (!dtack_n) begin
        resp_edge = c;
        if (!wr) chk("rd_data", cpu_dout, exp_rd);
        chk("doe", {cpu_doe_h, cpu_doe_l}, wr ? 2'b00 : lanes);
        break;
      end
      if (!berr_n) begin berr_edge = c; break; end
    end
    if (mapped && delay >= 0) begin
      chk("dtack_lat", resp_edge, 4 + delay);
      chk("req_cnt", req_cnt, 1);
    end else if (mapped) begin
      chk("req_edge", req_edge, 3);
      chk("berr_lat", berr_edge, 3 + TIMEOUT + 1);
    end else begin
`ifdef CPU_BRIDGE_BERR_EN
      chk("unmapped_berr", berr_edge, 3);
`else
      chk("unmapped_dtack", resp_edge, 3);
`endif
      chk("unmapped_req", req_cnt, 0);
    end
    if (rst_mid) begin
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      idle_inputs();
      repeat (2) @(negedge sysclk);
      rst_n = 1'b1;
      repeat (3) @(negedge sysclk);
    end else begin
      release_bus();
    end
  endtask

  task automatic run_iack(input bit av, input logic [7:0] vec);
    int iack_edge, resp_edge;
    iack_edge = -1; resp_edge = -1;
    @(negedge sysclk);
    cpu_fc = 3'b111; as_n = 1'b0; rdl_n = 1'b0; fpga_cs_n = 1'b1;
    iack_vector = vec; iack_autovec = av; iack_ack = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge sysclk);
      if (!iack_cycle_n && iack_edge < 0) begin
        iack_edge = c;
        iack_ack = 1'b1;
      end
      if (!dtack_n || !vpa_n) begin resp_edge = c; break; end
    end
    chk("iack_edge", iack_edge, 3);
    chk("iack_resp_bound", 32'(resp_edge > iack_edge && resp_edge <= iack_edge + 2), 1);
    chk("iack_vpa_n", vpa_n, !av);
    chk("iack_dtack_n", dtack_n, av);
    chk("iack_cycle_n_low", iack_cycle_n, 0);
    if (!av) begin
      chk("iack_vector", cpu_dout[7:0], vec);
      chk("iack_doe", {cpu_doe_h, cpu_doe_l}, 2'b01);
    end
    release_bus();
  endtask

  task automatic run_abort();
    bit seen;
    seen = 0;
    @(negedge sysclk);
    cpu_addr = 19'h33; cpu_fc = 3'b101; fpga_cs_n = 1'b0; as_n = 1'b0; rdh_n = 1'b0; rdl_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sysclk);
      if (slot_req) begin seen = 1; break; end
    end
    chk("abort_req", seen, 1);
    repeat (5) @(negedge sysclk);
    chk("abort_wait_dtack", dtack_n, 1);
    idle_inputs();
    repeat (4) @(negedge sysclk);
    slot_ack[3] = 1'b1;
    repeat (4) begin
      @(negedge sysclk);
      chk("abort_no_dtack", dtack_n, 1);
      chk("abort_no_berr", berr_n, 1);
    end
    slot_ack = '0;
    chk("abort_idle_sel", slot_sel, 0);
  endtask

  task automatic randomize_rdata();
    for (int i = 0; i < NSLOT; i++) slot_rdata[16*i +: 16] = 16'($urandom);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0; cpu_addr = '0; cpu_din = '0; iack_vector = '0; iack_autovec = 1'b0;
    randomize_rdata();
    repeat (3) @(negedge sysclk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    run_access('h23, 1'b0, 2'b11, 16'h0000, 0, 1'b0);
    run_access('h05, 1'b1, 2'b10, 16'hA55A, 0, 1'b0);
    run_access('h5A, 1'b0, 2'b11, 16'h0000, 10, 1'b0);
    run_access('h800, 1'b0, 2'b11, 16'h0000, 0, 1'b0);
`ifdef CPU_BRIDGE_BERR_EN
    run_access('h61, 1'b0, 2'b01, 16'h0000, -1, 1'b0);
`endif
    run_iack(1'b0, 8'h40);
    run_iack(1'b1, 8'h40);
    run_abort();
    run_access('h34, 1'b0, 2'b01, 16'h0000, 1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      int  wa;
      bit  wr;
      logic [1:0] lanes;
      randomize_rdata();
      if ($urandom_range(0, 4) == 0) wa = int'($urandom_range(NSLOT * SLOT_WORDS, 19'h7FFFF));
      else                           wa = int'($urandom_range(0, NSLOT * SLOT_WORDS - 1));
      wr    = 1'($urandom_range(0, 1));
      lanes = 2'($urandom_range(1, 3));
      run_access(wa, wr, lanes, 16'($urandom), int'($urandom_range(0, 6)), 1'b0);
    end

    run_access('h12, 1'b0, 2'b11, 16'h0000, 2, 1'b1);
    run_access('h47, 1'b1, 2'b11, 16'h1234, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
